mcs_fpro_bridge_gen: RTL and testbench

//  Parametrised MicroBlaze MCS IO-bus to FPro-bus bridge. Decodes the MCS IO window at
//  BRG_BASE into 2**CS_BITS FPro slot regions (mmio, video, ...). Adds registered

---
 rtl/mcs_fpro_bridge_gen_if.sv | 44 ++++
 rtl/mcs_fpro_bridge_gen.sv | 137 +++++++++++++
 tb/tb_mcs_fpro_bridge_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcs_fpro_bridge_gen_if.sv
// Bus bundle between the MicroBlaze MCS IO bus, the bridge and the FPro slot regions.
// The slave modport is the bridge; the master modport is the CPU plus the FPro subsystems.
interface mcs_fpro_bridge_gen_if #(
    parameter int CS_BITS = 1
);
    localparam int N_CS   = 2 ** CS_BITS;
    localparam int ADDR_W = 22 - CS_BITS;

    // MCS IO side
    logic                 io_addr_strobe;
    logic                 io_read_strobe;
    logic                 io_write_strobe;
    logic [3:0]           io_byte_enable;
    logic [31:0]          io_address;
    logic [31:0]          io_write_data;
    logic [31:0]          io_read_data;
    logic                 io_ready;

    // FPro side
    logic [N_CS-1:0]      fp_cs;
    logic                 fp_wr;
    logic                 fp_rd;
    logic [ADDR_W-1:0]    fp_addr;
    logic [3:0]           fp_be;
    logic [31:0]          fp_wr_data;
    logic [32*N_CS-1:0]   fp_rd_data;
    logic [N_CS-1:0]      fp_ack;

    modport slave (
        input  io_addr_strobe, io_read_strobe, io_write_strobe,
        input  io_byte_enable, io_address, io_write_data,
        output io_read_data, io_ready,
        output fp_cs, fp_wr, fp_rd, fp_addr, fp_be, fp_wr_data,
        input  fp_rd_data, fp_ack
    );

    modport master (
        output io_addr_strobe, io_read_strobe, io_write_strobe,
        output io_byte_enable, io_address, io_write_data,
        input  io_read_data, io_ready,
        input  fp_cs, fp_wr, fp_rd, fp_addr, fp_be, fp_wr_data,
        output fp_rd_data, fp_ack
    );
endinterface

// File: rtl/mcs_fpro_bridge_gen.sv
// MCS IO-bus to FPro-bus bridge with per-region wait-state handshake.
// Optional BRG_TIMEOUT_EN enables the WAIT timeout, DEAD_BEEF read data and sticky brg_err.
module mcs_fpro_bridge_gen #(
    parameter logic [31:0] BRG_BASE    = 32'hc000_0000,
    parameter int          CS_BITS     = 1,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    mcs_fpro_bridge_gen_if.slave  bus,
    output logic                  brg_err,
    input  logic                  brg_err_clr
);
    localparam int N_CS   = 2 ** CS_BITS;
    localparam int ADDR_W = 22 - CS_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state;
    logic [CS_BITS-1:0]  region;
    logic                is_wr;

    logic                start;
    logic [CS_BITS-1:0]  req_region;
    logic [N_CS-1:0]     req_cs;
    logic                sel_ack;
    logic [31:0]         ack_data;

    assign start      = bus.io_addr_strobe
                      && (bus.io_address[31:24] == BRG_BASE[31:24])
                      && (bus.io_read_strobe || bus.io_write_strobe);
    assign req_region = bus.io_address[23 -: CS_BITS];
    assign req_cs     = N_CS'(1) << req_region;
    // Only the latched region's ack and read slice are ever looked at.
    assign sel_ack    = bus.fp_ack[region];
    assign ack_data   = is_wr ? 32'h0 : bus.fp_rd_data[int'(region) * 32 +: 32];

`ifdef BRG_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;
    logic             unused_bits;
    assign unused_bits = ^bus.io_address[1:0];
`else
    logic             unused_bits;
    assign unused_bits = ^{bus.io_address[1:0], brg_err_clr};
    assign brg_err     = 1'b0;
`endif

    // NOTE: every register below is assigned with <= so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            region           <= '0;
            is_wr            <= 1'b0;
            bus.io_ready     <= 1'b0;
            bus.io_read_data <= '0;
            bus.fp_cs        <= '0;
            bus.fp_wr        <= 1'b0;
            bus.fp_rd        <= 1'b0;
            bus.fp_addr      <= '0;
            bus.fp_be        <= '0;
            bus.fp_wr_data   <= '0;
`ifdef BRG_TIMEOUT_EN
            cnt              <= '0;
            brg_err          <= 1'b0;
`endif
        end else begin
`ifdef BRG_TIMEOUT_EN
            // A timeout later in this block overrides the clear: set wins.
            if (brg_err_clr) brg_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_ISSUE;
                        region         <= req_region;
                        is_wr          <= bus.io_write_strobe;
                        bus.fp_cs      <= req_cs;
                        bus.fp_wr      <= bus.io_write_strobe;
                        bus.fp_rd      <= ~bus.io_write_strobe;
                        bus.fp_addr    <= bus.io_address[ADDR_W+1:2];
                        bus.fp_be      <= bus.io_byte_enable;
                        bus.fp_wr_data <= bus.io_write_data;
                    end
                end
                S_ISSUE: begin
                    bus.fp_wr <= 1'b0;
                    bus.fp_rd <= 1'b0;
`ifdef BRG_TIMEOUT_EN
                    cnt       <= '0;
`endif
                    if (sel_ack) begin
                        state            <= S_RESP;
                        bus.fp_cs        <= '0;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= ack_data;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sel_ack) begin
                        state            <= S_RESP;
                        bus.fp_cs        <= '0;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= ack_data;
                    end
`ifdef BRG_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        state            <= S_RESP;
                        bus.fp_cs        <= '0;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= 32'hDEAD_BEEF;
                        brg_err          <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    state            <= S_IDLE;
                    bus.io_ready     <= 1'b0;
                    bus.io_read_data <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcs_fpro_bridge_gen.sv
// Directed bench: dut1 (CS_BITS=1, TIMEOUT_CYC=4) and dut2 (CS_BITS=2) share clk/reset.
module tb_mcs_fpro_bridge_gen;
    logic clk = 1'b0;
    logic reset;
    logic err1, clr1, err2, clr2;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mcs_fpro_bridge_gen_if #(.CS_BITS(1)) bus1 ();
    mcs_fpro_bridge_gen_if #(.CS_BITS(2)) bus2 ();

    mcs_fpro_bridge_gen #(.BRG_BASE(32'hc000_0000), .CS_BITS(1), .TIMEOUT_CYC(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .brg_err(err1), .brg_err_clr(clr1)
    );
    mcs_fpro_bridge_gen #(.BRG_BASE(32'hc000_0000), .CS_BITS(2), .TIMEOUT_CYC(255)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .brg_err(err2), .brg_err_clr(clr2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        bus1.io_addr_strobe  = rd | wr;
        bus1.io_read_strobe  = rd;
        bus1.io_write_strobe = wr;
        bus1.io_address      = addr;
        bus1.io_byte_enable  = be;
        bus1.io_write_data   = wdata;
    endtask

    task automatic idle1();
        drive1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic check_all_zero1(input string tag);
        check({tag, ".io_ready"},     bus1.io_ready,     64'h0);
        check({tag, ".io_read_data"}, bus1.io_read_data, 64'h0);
        check({tag, ".fp_cs"},        bus1.fp_cs,        64'h0);
        check({tag, ".fp_rd_wr"},     {bus1.fp_rd, bus1.fp_wr}, 64'h0);
        check({tag, ".fp_addr"},      bus1.fp_addr,      64'h0);
        check({tag, ".fp_be"},        bus1.fp_be,        64'h0);
        check({tag, ".fp_wr_data"},   bus1.fp_wr_data,   64'h0);
        check({tag, ".brg_err"},      err1,              64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr1 = 1'b0; clr2 = 1'b0;
        idle1();
        bus1.fp_ack = '0; bus1.fp_rd_data = '0;
        bus2.io_addr_strobe = 1'b0; bus2.io_read_strobe = 1'b0; bus2.io_write_strobe = 1'b0;
        bus2.io_address = '0; bus2.io_byte_enable = '0; bus2.io_write_data = '0;
        bus2.fp_ack = '0; bus2.fp_rd_data = '0;
        tick(); tick();
        check_all_zero1("reset");
        check("reset.dut2_cs", bus2.fp_cs, 64'h0);
        reset = 1'b0;
        tick();

        // 1: zero-wait read, region 0 acks in ISSUE
        bus1.fp_rd_data = {32'h9999_9999, 32'h1234_5678};
        bus1.fp_ack     = 2'b01;
        drive1(1'b1, 1'b0, 32'hc000_0010, 4'hF, 32'h0);
        tick(); idle1();
        check("t1.issue_cs",   bus1.fp_cs,    64'h1);
        check("t1.issue_rd",   bus1.fp_rd,    64'h1);
        check("t1.issue_wr",   bus1.fp_wr,    64'h0);
        check("t1.issue_addr", bus1.fp_addr,  64'h4);
        check("t1.issue_rdy",  bus1.io_ready, 64'h0);
        tick();
        check("t1.resp_rdy",   bus1.io_ready,     64'h1);
        check("t1.resp_data",  bus1.io_read_data, 64'h1234_5678);
        check("t1.resp_rd",    bus1.fp_rd,        64'h0);
        check("t1.resp_cs",    bus1.fp_cs,        64'h0);
        tick();
        check("t1.after_rdy",  bus1.io_ready,     64'h0);
        check("t1.after_data", bus1.io_read_data, 64'h0);
        bus1.fp_ack = '0;

        // 2: write to region 1, ack in the third WAIT cycle; region 0 ack ignored
        bus1.fp_rd_data = {32'h7777_7777, 32'h5555_5555};
        drive1(1'b0, 1'b1, 32'hc080_0004, 4'b0011, 32'hA5A5_0001);
        tick(); idle1();
        check("t2.issue_cs",    bus1.fp_cs,      64'h2);
        check("t2.issue_wr",    bus1.fp_wr,      64'h1);
        check("t2.issue_rd",    bus1.fp_rd,      64'h0);
        check("t2.issue_addr",  bus1.fp_addr,    64'h1);
        check("t2.issue_be",    bus1.fp_be,      64'h3);
        check("t2.issue_wdata", bus1.fp_wr_data, 64'hA5A5_0001);
        tick();
        check("t2.wait1_cs",  bus1.fp_cs,    64'h2);
        check("t2.wait1_wr",  bus1.fp_wr,    64'h0);
        check("t2.wait1_rdy", bus1.io_ready, 64'h0);
        bus1.fp_ack = 2'b01;
        tick();
        check("t2.wait2_rdy", bus1.io_ready, 64'h0);
        check("t2.wait2_cs",  bus1.fp_cs,    64'h2);
        bus1.fp_ack = 2'b00;
        tick();
        check("t2.wait3_rdy", bus1.io_ready, 64'h0);
        check("t2.wait3_be",  bus1.fp_be,    64'h3);
        bus1.fp_ack = 2'b10;
        tick();
        check("t2.resp_rdy",  bus1.io_ready,     64'h1);
        check("t2.resp_data", bus1.io_read_data, 64'h0);
        check("t2.resp_cs",   bus1.fp_cs,        64'h0);
        bus1.fp_ack = 2'b00;
        tick();
        check("t2.after_rdy", bus1.io_ready, 64'h0);

`ifdef BRG_TIMEOUT_EN
        // 3: timeout after 4 WAIT cycles, then sticky error and clear
        drive1(1'b1, 1'b0, 32'hc000_0020, 4'hF, 32'h0);
        tick(); idle1();
        check("t3.issue_rd", bus1.fp_rd, 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3.wait%0d_rdy", i + 1), bus1.io_ready, 64'h0);
            check($sformatf("t3.wait%0d_err", i + 1), err1,          64'h0);
        end
        tick();
        check("t3.resp_rdy",  bus1.io_ready,     64'h1);
        check("t3.resp_data", bus1.io_read_data, 64'hDEAD_BEEF);
        check("t3.resp_err",  err1,              64'h1);
        tick();
        check("t3.sticky_err", err1, 64'h1);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        check("t3.cleared_err", err1, 64'h0);

        // timeout with brg_err_clr held high: set wins
        clr1 = 1'b1;
        drive1(1'b1, 1'b0, 32'hc000_0020, 4'hF, 32'h0);
        tick(); idle1();
        for (int i = 0; i < 5; i++) tick();
        check("t3b.resp_rdy", bus1.io_ready, 64'h1);
        check("t3b.set_wins", err1,          64'h1);
        clr1 = 1'b0;
        tick();
        check("t3b.sticky", err1, 64'h1);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        check("t3b.cleared", err1, 64'h0);
`else
        // 3 (timeout disabled): WAIT holds indefinitely until the ack arrives
        drive1(1'b1, 1'b0, 32'hc000_0020, 4'hF, 32'h0);
        tick(); idle1();
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t3.hold%0d_rdy", i + 1), bus1.io_ready, 64'h0);
        end
        check("t3.hold_cs",  bus1.fp_cs, 64'h1);
        check("t3.hold_err", err1,       64'h0);
        bus1.fp_ack = 2'b01;
        tick();
        bus1.fp_ack = 2'b00;
        check("t3.resp_rdy",  bus1.io_ready,     64'h1);
        check("t3.resp_data", bus1.io_read_data, 64'h5555_5555);
        tick();
`endif

        // 4: strobe outside the bridge window is ignored
        bus1.fp_ack = 2'b11;
        drive1(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
        tick(); idle1();
        check("t4.no_cs", bus1.fp_cs, 64'h0);
        check("t4.no_rd", bus1.fp_rd, 64'h0);
        tick();
        check("t4.no_rdy1", bus1.io_ready, 64'h0);
        tick();
        check("t4.no_rdy2", bus1.io_ready, 64'h0);
        bus1.fp_ack = 2'b00;

        // 5: reset in WAIT aborts, then a normal transaction completes
        drive1(1'b0, 1'b1, 32'hc080_0008, 4'b1100, 32'h0BAD_F00D);
        tick(); idle1();
        tick();
        check("t5.in_wait_cs", bus1.fp_cs, 64'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero1("t5.reset");
        bus1.fp_ack = 2'b10;
        tick();
        check("t5.no_rdy1", bus1.io_ready, 64'h0);
        tick();
        check("t5.no_rdy2", bus1.io_ready, 64'h0);
        bus1.fp_rd_data = {32'hCAFE_0002, 32'h0};
        drive1(1'b1, 1'b0, 32'hc080_000C, 4'hF, 32'h0);
        tick(); idle1();
        check("t5.re_cs",   bus1.fp_cs,   64'h2);
        check("t5.re_addr", bus1.fp_addr, 64'h3);
        tick();
        check("t5.re_rdy",  bus1.io_ready,     64'h1);
        check("t5.re_data", bus1.io_read_data, 64'hCAFE_0002);
        bus1.fp_ack = 2'b00;
        tick();

        // 6: CS_BITS=2, region 3; ack from region 0 ignored
        bus2.fp_rd_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_00AA};
        bus2.fp_ack = 4'b0001;
        bus2.io_addr_strobe = 1'b1; bus2.io_read_strobe = 1'b1;
        bus2.io_address = 32'hc0c0_0008; bus2.io_byte_enable = 4'hF;
        tick();
        bus2.io_addr_strobe = 1'b0; bus2.io_read_strobe = 1'b0;
        check("t6.issue_cs",   bus2.fp_cs,   64'h8);
        check("t6.issue_addr", bus2.fp_addr, 64'h2);
        check("t6.issue_rd",   bus2.fp_rd,   64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6.wait%0d_rdy", i + 1), bus2.io_ready, 64'h0);
        end
        check("t6.wait_cs", bus2.fp_cs, 64'h8);
        bus2.fp_ack = 4'b1000;
        tick();
        bus2.fp_ack = 4'b0000;
        check("t6.resp_rdy",  bus2.io_ready,     64'h1);
        check("t6.resp_data", bus2.io_read_data, 64'h3333_3333);
        tick();
        check("t6.after_rdy", bus2.io_ready, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
